// File: rtl/core_frame_ctrl.sv
// Frame controller: takes a mode header, buffers a frame in RAM, hands the RAM to an
// FFT/FIR accelerator (or skips it in bypass), then streams the results out over tx_done.
module core_frame_ctrl #(
    parameter int DATA_W  = 16,
    parameter int DEPTH   = 128,
    parameter int IN_LEN  = 64,
    parameter int OUT_LEN = 128,
    parameter int TIMEOUT = 4096,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_in_valid,
    input  logic              tx_done,
    output logic [DATA_W-1:0] data_out,
    output logic              data_out_valid,
    output logic              core_busy,
    output logic              acc_start,
    output logic [1:0]        acc_mode,
    input  logic [ADDR_W-1:0] acc_addr,
    output logic [DATA_W-1:0] acc_rdata,
    input  logic [DATA_W-1:0] acc_wdata,
    input  logic              acc_we,
    input  logic              acc_done,
    output logic              err_timeout
);
    localparam int CNT_W = ADDR_W + 1;
    localparam int TMO_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] IN_LAST  = CNT_W'(IN_LEN - 1);
    localparam logic [CNT_W-1:0] OUT_LAST = CNT_W'(OUT_LEN - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, RECEIVE, COMPUTE, TRANSMIT} state_t;

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [CNT_W-1:0]  out_last_reg, out_last_next;
    logic [TMO_W-1:0]  tmo_reg, tmo_next;
    logic              bypass_reg, bypass_next;
    logic [1:0]        acc_mode_reg, acc_mode_next;
    logic              err_reg, err_next;
    logic              valid_reg, valid_next;
    logic              load_reg, load_next;
    logic              acc_start_reg, acc_start_next;
    logic              rx_prev_reg, tx_prev_reg;
    logic [DATA_W-1:0] data_out_reg;
    logic [DATA_W-1:0] acc_rdata_reg;

    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] mem [DEPTH];

    logic rx_edge, tx_edge;
    assign rx_edge = data_in_valid & ~rx_prev_reg;
    assign tx_edge = tx_done & ~tx_prev_reg;

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        out_last_next  = out_last_reg;
        tmo_next       = tmo_reg;
        bypass_next    = bypass_reg;
        acc_mode_next  = acc_mode_reg;
        err_next       = err_reg;
        valid_next     = valid_reg;
        load_next      = 1'b0;
        acc_start_next = 1'b0;
        ram_we         = 1'b0;
        ram_waddr      = acc_addr;
        ram_wdata      = acc_wdata;
        case (state_reg)
            IDLE: begin
                if (rx_edge) begin
                    case (data_in[1:0])
                        2'b00, 2'b01: begin
                            acc_mode_next = data_in[1:0];
                            bypass_next   = 1'b0;
                            err_next      = 1'b0;
                            cnt_next      = '0;
                            state_next    = RECEIVE;
                        end
                        2'b10: begin
                            bypass_next = 1'b1;
                            err_next    = 1'b0;
                            cnt_next    = '0;
                            state_next  = RECEIVE;
                        end
                        default: ;
                    endcase
                end
            end
            RECEIVE: begin
                if (rx_edge) begin
                    ram_we    = 1'b1;
                    ram_waddr = cnt_reg[ADDR_W-1:0];
                    ram_wdata = data_in;
                    if (cnt_reg == IN_LAST) begin
                        cnt_next = '0;
                        if (bypass_reg) begin
                            state_next    = TRANSMIT;
                            out_last_next = IN_LAST;
                            load_next     = 1'b1;
                        end else begin
                            state_next     = COMPUTE;
                            tmo_next       = '0;
                            acc_start_next = 1'b1;
                        end
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            end
            COMPUTE: begin
                ram_we = acc_we;
                if (acc_done) begin
                    state_next    = TRANSMIT;
                    out_last_next = OUT_LAST;
                    cnt_next      = '0;
                    load_next     = 1'b1;
                end else if (tmo_reg == TMO_LAST) begin
                    err_next   = 1'b1;
                    state_next = IDLE;
                end else begin
                    tmo_next = tmo_reg + 1'b1;
                end
            end
            TRANSMIT: begin
                // A load cycle never coincides with a tx edge: edges need a low cycle in between.
                if (load_reg) begin
                    valid_next = 1'b1;
                end else if (tx_edge && valid_reg) begin
                    if (cnt_reg == out_last_reg) begin
                        valid_next = 1'b0;
                        cnt_next   = '0;
                        state_next = IDLE;
                    end else begin
                        cnt_next  = cnt_reg + 1'b1;
                        load_next = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            out_last_reg  <= '0;
            tmo_reg       <= '0;
            bypass_reg    <= 1'b0;
            acc_mode_reg  <= 2'b00;
            err_reg       <= 1'b0;
            valid_reg     <= 1'b0;
            load_reg      <= 1'b0;
            acc_start_reg <= 1'b0;
            rx_prev_reg   <= 1'b1;
            tx_prev_reg   <= 1'b1;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            out_last_reg  <= out_last_next;
            tmo_reg       <= tmo_next;
            bypass_reg    <= bypass_next;
            acc_mode_reg  <= acc_mode_next;
            err_reg       <= err_next;
            valid_reg     <= valid_next;
            load_reg      <= load_next;
            acc_start_reg <= acc_start_next;
            rx_prev_reg   <= data_in_valid;
            tx_prev_reg   <= tx_done;
        end
    end

    // Frame RAM: one write port shared by RX and the accelerator, registered reads.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[ram_waddr] <= ram_wdata;
        end
        acc_rdata_reg <= mem[acc_addr];
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            data_out_reg <= '0;
        end else if (state_reg == TRANSMIT && load_reg) begin
            data_out_reg <= mem[cnt_reg[ADDR_W-1:0]];
        end
    end

    assign data_out       = data_out_reg;
    assign data_out_valid = valid_reg;
    assign core_busy      = (state_reg == COMPUTE) || (state_reg == TRANSMIT);
    assign acc_start      = acc_start_reg;
    assign acc_mode       = acc_mode_reg;
    assign acc_rdata      = acc_rdata_reg;
    assign err_timeout    = err_reg;
endmodule

// File: doc/core_frame_ctrl.md
Name: core_frame_ctrl

Overview:
- Parametrised frame controller between the serial RX/TX channel and the DSP accelerators (FFT/FIR).
- Takes a mode header, then buffers IN_LEN samples in an internal frame RAM.
- Hands the RAM to the selected accelerator and waits for it to finish, with a timeout.
- Streams OUT_LEN result words back over the tx_done handshake. Adds a bypass mode, timeout/error reporting and width/depth generics.

Parameters:
- DATA_W, 16, sample/word width.
- DEPTH, 128, frame RAM words; ADDR_W = $clog2(DEPTH) is derived.
- IN_LEN, 64, samples received per frame (1..DEPTH).
- OUT_LEN, 128, words transmitted after FFT/FIR compute (1..DEPTH).
- TIMEOUT, 4096, max clk cycles in COMPUTE before abort (≥2).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rstb  in  1  reset; synchronous, active-low.
- data_in  in  DATA_W  RX word.
- data_in_valid  in  1  RX strobe; each rising edge = one new word.
- tx_done  in  1  TX ack; each rising edge = current word consumed.
- data_out  out  DATA_W  TX word.
- data_out_valid  out  1  data_out holds a word awaiting ack.
- core_busy  out  1  high in COMPUTE and TRANSMIT.
- acc_start  out  1  one-cycle start pulse to the accelerator.
- acc_mode  out  2  latched mode: 00 FFT, 01 FIR.
- acc_addr  in  ADDR_W  accelerator RAM address.
- acc_rdata  out  DATA_W  RAM[acc_addr], registered, 1-cycle latency.
- acc_wdata  in  DATA_W  accelerator write data.
- acc_we  in  1  accelerator write enable; honoured only in COMPUTE.
- acc_done  in  1  accelerator finished (pulse or level).
- err_timeout  out  1  sticky compute-timeout flag.

Behaviour:
- Reset (rstb=0 at a clk edge):
  - state=IDLE; all counters 0.
  - data_out=0, data_out_valid=0, core_busy=0, acc_start=0, acc_mode=0, err_timeout=0.
  - RAM contents undefined.
  - data_in_valid_prev and tx_done_prev reset to 1, so a level held high through reset release is not an edge.
  - Reset mid-frame aborts immediately; no partial output.
- Edges: rx_edge = data_in_valid & ~data_in_valid_prev; tx_edge = tx_done & ~tx_done_prev. Both prev regs update every cycle in every state.
- IDLE:
  - On rx_edge, decode data_in[1:0]; the header word is not stored.
  - 00/01: latch acc_mode, clear err_timeout, go to RECEIVE.
  - 10: bypass, clear err_timeout, go to RECEIVE.
  - 11: ignored; stay in IDLE, err_timeout unchanged.
- RECEIVE:
  - Each rx_edge writes RAM[cnt]=data_in and increments cnt.
  - On the IN_LEN-th word: cnt←0.
  - FFT/FIR: go to COMPUTE with acc_start=1 for exactly the next cycle.
  - Bypass: go to TRANSMIT with out_len=IN_LEN.
  - No timeout while receiving.
- COMPUTE:
  - Accelerator owns the RAM: acc_we writes RAM[acc_addr]=acc_wdata; acc_rdata is always registered.
  - The tmo counter starts at 0 and increments each cycle.
  - acc_done=1 (including in the first cycle): go to TRANSMIT, out_len=OUT_LEN.
  - Otherwise, when tmo reaches TIMEOUT-1: err_timeout←1, go to IDLE.
  - If acc_done and the timeout coincide, acc_done wins.
  - rx edges are ignored; RX words are dropped.
- TRANSMIT:
  - On entry, data_out=RAM[0] and data_out_valid=1 (1 cycle after the state change, due to RAM read latency).
  - On tx_edge with index<out_len-1: index++; data_out updates to the next word, with data_out_valid held high.
  - On tx_edge of the last word: data_out_valid←0, data_out holds its value, go to IDLE.
  - tx edges while data_out_valid=0 are ignored.
  - rx edges are ignored.
- RAM port priority: RX write (RECEIVE) / acc port (COMPUTE) / TX read (TRANSMIT) are mutually exclusive by state.
- Widths: all counters are ADDR_W+1 bits; no wrap is possible because IN_LEN and OUT_LEN are ≤ DEPTH.
- core_busy is combinational from state.

Test Plan:
1. Bypass: header 0x0002, then 64 words 0x1000..0x103F via rx edges → no acc_start; core_busy=1 in TRANSMIT; data_out=0x1000 valid; after 64 tx edges the sequence 0x1000..0x103F is observed and data_out_valid=0, state IDLE.
2. FFT: header 0x0000, 64 samples; model writes RAM[i]=i*3 for i=0..127 and pulses acc_done at cycle 200 → single acc_start pulse, acc_mode=00; 128 words 0,3,...,381 transmitted in order.
3. Timeout: header 0x0001, 64 samples, acc_done never asserted → err_timeout=1 exactly 4096 cycles after entering COMPUTE, state IDLE, data_out_valid=0; next header 0x0000 clears err_timeout.
4. Ignored/level inputs: header 0x0003 → stay IDLE. data_in_valid held high for 10 cycles → one word only. tx_done held high → one advance only. rx edges during COMPUTE → RAM unchanged.
5. Reset mid-op: assert rstb=0 after word 30 of RECEIVE, and separately after word 5 of TRANSMIT → all outputs at reset values next cycle. With data_in_valid held high across reset release, no word is captured.
6. Parameter sweep: DATA_W=24, DEPTH=16, IN_LEN=16, OUT_LEN=8, bypass and FIR → correct counts; bypass echoes 16 words, FIR returns 8.
